// File: rtl/axis_arb_pkg.sv
// Shared types and index-width helper for the AXI-stream packet arbiter.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_PASS} arb_state_t;

  // A single source still needs a 1-bit index.
  function automatic int unsigned src_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned SRC_IDX_W   = src_idx_w(NUM_SRC_DEF);

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
module rr_priority_pick
  import axis_arb_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = src_idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);

  localparam logic [W:0] N_W = N[W:0];

  logic [N-1:0] rot;
  logic [W:0]   off;
  logic [W:0]   sum;
  logic         found;

  // Rotating the doubled vector right by ptr puts req[ptr] at bit 0.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    any   = |req;
    off   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        off   = i[W:0];
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + off;
    if (sum >= N_W) sum = sum - N_W;
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: grant locks on the first beat and
// releases only after the tlast beat is accepted.
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned AXI_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC*AXI_WIDTH-1:0]   s_axis_data,
  input  logic [NUM_SRC-1:0]             s_axis_valid,
  input  logic [NUM_SRC-1:0]             s_axis_last,
  output logic [NUM_SRC-1:0]             s_axis_ready,
  output logic [AXI_WIDTH-1:0]           m_axis_data,
  output logic                           m_axis_valid,
  output logic                           m_axis_last,
  input  logic                           m_axis_ready,
  output logic [src_idx_w(NUM_SRC)-1:0]  grant_id,
  output logic                           busy
);

  localparam int unsigned IDX_W = src_idx_w(NUM_SRC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_priority_pick #(.N(NUM_SRC), .W(IDX_W)) u_pick (
    .req (s_axis_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    s_axis_ready = '0;
    m_axis_data  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ARB_PASS;
        end
      end
      ARB_PASS: begin
        m_axis_data           = s_axis_data[grant_q*AXI_WIDTH +: AXI_WIDTH];
        m_axis_valid          = s_axis_valid[grant_q];
        m_axis_last           = s_axis_last[grant_q];
        s_axis_ready[grant_q] = m_axis_ready;
        if (m_axis_valid && m_axis_ready && m_axis_last) begin
          rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign grant_id = grant_q;
  assign busy     = (state_q == ARB_PASS);

endmodule
